// File: rtl/captura_veiculo.sv
// captura_veiculo: weigh-station front-end. Measures one vehicle at a time:
// peak-holds the weight, counts debounced axle pulses, and presents the
// result on p3..p0 / e1,e0 under a valid/accept handshake.
module captura_veiculo #(
  parameter int FILTRO  = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_entrada,
  input  logic       pulso_eixo,
  input  logic [3:0] peso_adc,
  input  logic       aceito,
  output logic       p3,
  output logic       p2,
  output logic       p1,
  output logic       p0,
  output logic       e1,
  output logic       e0,
  output logic       excesso,
  output logic       valido,
  output logic       timeout
);

  // The filter counter must hold the value FILTRO itself (it saturates there).
  localparam int FW = $clog2(FILTRO + 1);
  // The timeout counter never exceeds TIMEOUT-1: reaching it aborts instead.
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [FW-1:0] FILTRO_LIM  = FW'(FILTRO);
  localparam logic [FW-1:0] FILTRO_PRE  = FW'(FILTRO - 1);
  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    MEDINDO = 2'd1,
    ENTREGA = 2'd2,
    ABORTA  = 2'd3
  } estado_t;

  estado_t estado_q, estado_d;

  logic          armado_q, armado_d;
  logic [3:0]    peso_pico_q, peso_pico_d;
  logic [1:0]    eixos_q, eixos_d;
  logic          excesso_int_q, excesso_int_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [TW-1:0] tempo_q, tempo_d;

  logic [3:0]    peso_out_q, peso_out_d;
  logic [1:0]    eixos_out_q, eixos_out_d;
  logic          excesso_out_q, excesso_out_d;
  logic          valido_q, valido_d;

  logic [FW-1:0] filt_prox;
  logic          eixo_contado;
  logic          timeout_s;

  // Axle debounce: count consecutive high cycles, saturate at FILTRO, and
  // flag an axle only on the cycle the count first reaches FILTRO.
  always_comb begin
    filt_prox    = '0;
    eixo_contado = 1'b0;
    if (pulso_eixo) begin
      if (filt_q == FILTRO_LIM) begin
        filt_prox = filt_q;
      end else begin
        filt_prox    = filt_q + 1'b1;
        eixo_contado = (filt_q == FILTRO_PRE);
      end
    end
  end

  // Next-state and datapath updates for the measurement sequence.
  always_comb begin
    estado_d      = estado_q;
    armado_d      = armado_q;
    peso_pico_d   = peso_pico_q;
    eixos_d       = eixos_q;
    excesso_int_d = excesso_int_q;
    filt_d        = filt_q;
    tempo_d       = tempo_q;
    peso_out_d    = peso_out_q;
    eixos_out_d   = eixos_out_q;
    excesso_out_d = excesso_out_q;
    valido_d      = valido_q;
    timeout_s     = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (!sensor_entrada) begin
          armado_d = 1'b1;
        end else if (armado_q) begin
          estado_d      = MEDINDO;
          peso_pico_d   = peso_adc;
          eixos_d       = 2'd0;
          excesso_int_d = 1'b0;
          filt_d        = '0;
          tempo_d       = '0;
        end
      end

      MEDINDO: begin
        if (!sensor_entrada) begin
          // Vehicle left: publish the result. A pulse still filtering is dropped.
          estado_d      = ENTREGA;
          peso_out_d    = peso_pico_q;
          eixos_out_d   = eixos_q;
          excesso_out_d = excesso_int_q;
          valido_d      = 1'b1;
        end else if (tempo_q == TIMEOUT_LIM) begin
          estado_d  = ABORTA;
          timeout_s = 1'b1;
        end else begin
          if (peso_adc > peso_pico_q) begin
            peso_pico_d = peso_adc;
          end
          filt_d = filt_prox;
          if (eixo_contado) begin
            if (eixos_q == 2'd3) begin
              excesso_int_d = 1'b1;
            end else begin
              eixos_d = eixos_q + 2'd1;
            end
          end
          tempo_d = tempo_q + 1'b1;
        end
      end

      ENTREGA: begin
        if (aceito) begin
          estado_d = OCIOSO;
          valido_d = 1'b0;
          armado_d = 1'b0;
        end
      end

      ABORTA: begin
        // Leaving on a sampled-low sensor means the idle state starts armed.
        if (!sensor_entrada) begin
          estado_d = OCIOSO;
          armado_d = 1'b1;
        end
      end

      default: begin
        estado_d = OCIOSO;
        armado_d = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q      <= OCIOSO;
      armado_q      <= 1'b0;
      peso_pico_q   <= 4'd0;
      eixos_q       <= 2'd0;
      excesso_int_q <= 1'b0;
      filt_q        <= '0;
      tempo_q       <= '0;
      peso_out_q    <= 4'd0;
      eixos_out_q   <= 2'd0;
      excesso_out_q <= 1'b0;
      valido_q      <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      armado_q      <= armado_d;
      peso_pico_q   <= peso_pico_d;
      eixos_q       <= eixos_d;
      excesso_int_q <= excesso_int_d;
      filt_q        <= filt_d;
      tempo_q       <= tempo_d;
      peso_out_q    <= peso_out_d;
      eixos_out_q   <= eixos_out_d;
      excesso_out_q <= excesso_out_d;
      valido_q      <= valido_d;
    end
  end

  assign {p3, p2, p1, p0} = peso_out_q;
  assign {e1, e0}         = eixos_out_q;
  assign excesso          = excesso_out_q;
  assign valido           = valido_q;
  assign timeout          = timeout_s;

endmodule

// File: tb/tb_captura_veiculo.sv
// tb_captura_veiculo: scenario tasks drive vehicles through captura_veiculo;
// a reference model pushes the expected result to a queue that is popped
// when valido rises.
module tb_captura_veiculo;

  localparam int FILTRO  = 4;
  localparam int TIMEOUT = 50;
  localparam int MAXLEN  = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_entrada;
  logic       pulso_eixo;
  logic [3:0] peso_adc;
  logic       aceito;
  logic       p3, p2, p1, p0, e1, e0, excesso, valido, timeout;
  logic [6:0] out_vec;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];
  logic [6:0] last_out;
  logic       pulso_pat[MAXLEN];
  logic [3:0] peso_pat[MAXLEN];

  captura_veiculo #(.FILTRO(FILTRO), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sensor_entrada(sensor_entrada), .pulso_eixo(pulso_eixo),
    .peso_adc(peso_adc), .aceito(aceito),
    .p3(p3), .p2(p2), .p1(p1), .p0(p0), .e1(e1), .e0(e0),
    .excesso(excesso), .valido(valido), .timeout(timeout)
  );

  assign out_vec = {p3, p2, p1, p0, e1, e0, excesso};

  always #5 clk = ~clk;

  // Reference: index 0 is the entry cycle (loads the peak only), 1..len-1 measure.
  function automatic logic [6:0] modelo(input int len);
    logic [3:0] pk;
    logic [1:0] e;
    logic       ex;
    int         run, ax;
    pk = peso_pat[0]; run = 0; ax = 0; ex = 1'b0;
    for (int i = 1; i < len; i++) begin
      if (peso_pat[i] > pk) pk = peso_pat[i];
      if (pulso_pat[i]) begin
        run++;
        if (run == FILTRO) begin
          if (ax == 3) ex = 1'b1;
          else ax++;
        end
      end else begin
        run = 0;
      end
    end
    e = ax[1:0];
    return {pk, e, ex};
  endfunction

  task automatic clear_pat();
    for (int k = 0; k < MAXLEN; k++) begin
      pulso_pat[k] = 1'b0;
      peso_pat[k]  = 4'd0;
    end
  endtask

  task automatic set_pulse(input int start, input int len);
    for (int k = start; k < start + len && k < MAXLEN; k++) pulso_pat[k] = 1'b1;
  endtask

  task automatic set_weight(input int from, input int to, input logic [3:0] w);
    for (int k = from; k <= to && k < MAXLEN; k++) peso_pat[k] = w;
  endtask

  task automatic random_pat(input int len);
    int i, h, g;
    clear_pat();
    for (int k = 0; k < len; k++) peso_pat[k] = 4'($urandom_range(0, 15));
    i = 2;
    while (i < len) begin
      h = int'($urandom_range(1, 7));
      g = int'($urandom_range(1, 4));
      set_pulse(i, h);
      i += h + g;
    end
  endtask

  // Hold the sensor low for n cycles, counting any valido seen.
  task automatic idle(input int n, output int val_seen);
    val_seen = 0;
    for (int i = 0; i < n; i++) begin
      sensor_entrada = 1'b0;
      pulso_eixo     = 1'($urandom_range(0, 1));
      peso_adc       = 4'($urandom_range(0, 15));
      aceito         = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (valido) val_seen++;
      @(posedge clk); #1;
    end
  endtask

  // Hold the sensor high for len cycles playing the stored pattern.
  task automatic drive_high(input int len, input logic acc, output int to_cnt,
                            output int to_idx, output int val_seen, output int chg);
    to_cnt = 0; to_idx = -1; val_seen = 0; chg = 0;
    for (int i = 0; i < len; i++) begin
      sensor_entrada = 1'b1;
      pulso_eixo     = pulso_pat[i];
      peso_adc       = peso_pat[i];
      aceito         = acc;
      @(negedge clk);
      if (timeout) begin to_cnt++; to_idx = i; end
      if (valido) val_seen++;
      if (out_vec !== last_out) chg++;
      @(posedge clk); #1;
    end
  endtask

  // One complete vehicle: measure, deliver, hold for 'hold' extra cycles, accept.
  task automatic run_vehicle(input string name, input int len, input int hold, input logic acc);
    logic [6:0] exp;
    int to_cnt, to_idx, val_seen, chg;
    exp_q.push_back(modelo(len));
    drive_high(len, acc, to_cnt, to_idx, val_seen, chg);
    checks++;
    if (to_cnt != 0) begin
      errors++; $display("[TB] FAIL %s_no_timeout: timeout pulses %0d, required 0", name, to_cnt);
    end
    checks++;
    if (val_seen != 0 || chg != 0) begin
      errors++;
      $display("[TB] FAIL %s_quiet: valido cycles %0d output-change cycles %0d, required 0 0",
               name, val_seen, chg);
    end
    sensor_entrada = 1'b0;
    pulso_eixo     = pulso_pat[len];
    peso_adc       = 4'($urandom_range(0, 15));
    aceito         = acc;
    @(negedge clk);
    checks++;
    if (valido !== 1'b0) begin
      errors++; $display("[TB] FAIL %s_early: valido %b, required 0", name, valido);
    end
    @(posedge clk); #1;
    aceito         = (hold == 0);
    sensor_entrada = 1'($urandom_range(0, 1));
    pulso_eixo     = 1'($urandom_range(0, 1));
    peso_adc       = 4'($urandom_range(0, 15));
    @(negedge clk);
    checks++;
    if (valido !== 1'b1) begin
      errors++; $display("[TB] FAIL %s_latency: valido %b, required 1", name, valido);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("[TB] FAIL %s_scoreboard: queue empty, required one entry", name);
    end else begin
      exp = exp_q.pop_front();
      if (out_vec !== exp) begin
        errors++;
        $display("[TB] FAIL %s_result: got P=%b E=%b excesso=%b, required P=%b E=%b excesso=%b",
                 name, out_vec[6:3], out_vec[2:1], out_vec[0], exp[6:3], exp[2:1], exp[0]);
      end
      last_out = exp;
    end
    for (int h = 1; h <= hold; h++) begin
      @(posedge clk); #1;
      aceito         = (h == hold);
      sensor_entrada = 1'($urandom_range(0, 1));
      pulso_eixo     = 1'($urandom_range(0, 1));
      peso_adc       = 4'($urandom_range(0, 15));
      @(negedge clk);
      checks++;
      if (valido !== 1'b1 || out_vec !== last_out) begin
        errors++;
        $display("[TB] FAIL %s_hold%0d: valido %b out %b, required 1 %b", name, h, valido, out_vec, last_out);
      end
    end
    @(posedge clk); #1;
    aceito = 1'b0; sensor_entrada = 1'b0; pulso_eixo = 1'b0;
    @(negedge clk);
    checks++;
    if (valido !== 1'b0 || out_vec !== last_out) begin
      errors++;
      $display("[TB] FAIL %s_release: valido %b out %b, required 0 %b", name, valido, out_vec, last_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int v;
    rst = 1'b1;
    sensor_entrada = 1'($urandom_range(0, 1)); pulso_eixo = 1'($urandom_range(0, 1));
    peso_adc = 4'($urandom_range(0, 15)); aceito = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    sensor_entrada = 1'($urandom_range(0, 1)); pulso_eixo = 1'($urandom_range(0, 1));
    peso_adc = 4'($urandom_range(0, 15)); aceito = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    checks++;
    if (out_vec !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b, required 0000000", out_vec);
    end
    checks++;
    if (valido !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valido: got %b, required 0", valido);
    end
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_timeout: got %b, required 0", timeout);
    end
    rst = 1'b0;
    last_out = 7'b0;
    idle(3, v);
    checks++;
    if (v != 0) begin
      errors++; $display("[TB] FAIL reset_idle: valido cycles %0d, required 0", v);
    end
  endtask

  task automatic test_normal();
    clear_pat();
    set_weight(0, 9, 4'd5); set_weight(10, 19, 4'd9); set_weight(20, 29, 4'd7);
    set_pulse(4, 6); set_pulse(16, 6);
    run_vehicle("normal", 30, 5, 1'b0);
  endtask

  task automatic test_glitch();
    clear_pat();
    for (int k = 0; k < 20; k++) peso_pat[k] = 4'($urandom_range(0, 15));
    set_pulse(4, 3); set_pulse(10, 4); set_pulse(17, 8);
    run_vehicle("glitch", 20, 2, 1'b0);
  endtask

  task automatic test_overflow();
    clear_pat();
    set_weight(0, 39, 4'd3); peso_pat[20] = 4'd15;
    for (int a = 0; a < 5; a++) set_pulse(2 + a * 7, 5);
    run_vehicle("overflow", 40, 1, 1'b0);
    clear_pat();
    set_weight(0, 14, 4'd2); peso_pat[0] = 4'd11;
    set_pulse(3, 6);
    run_vehicle("after_overflow", 15, 1, 1'b0);
  endtask

  task automatic test_timeout();
    int to_cnt, to_idx, val_seen, chg, v;
    random_pat(60);
    drive_high(60, 1'b0, to_cnt, to_idx, val_seen, chg);
    checks++;
    if (to_cnt != 1) begin
      errors++; $display("[TB] FAIL timeout_count: pulses %0d, required 1", to_cnt);
    end
    checks++;
    if (to_idx != TIMEOUT) begin
      errors++; $display("[TB] FAIL timeout_cycle: pulse on measuring cycle %0d, required %0d", to_idx, TIMEOUT);
    end
    checks++;
    if (val_seen != 0 || chg != 0) begin
      errors++;
      $display("[TB] FAIL timeout_quiet: valido cycles %0d output-change cycles %0d, required 0 0", val_seen, chg);
    end
    idle(3, v);
    checks++;
    if (v != 0) begin
      errors++; $display("[TB] FAIL timeout_no_result: valido cycles %0d, required 0", v);
    end
    random_pat(20);
    run_vehicle("after_timeout", 20, 2, 1'b0);
    random_pat(TIMEOUT);
    run_vehicle("fall_at_limit", TIMEOUT, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    random_pat(15);
    run_vehicle("b2b_a", 15, 0, 1'b1);
    random_pat(18);
    run_vehicle("b2b_b", 18, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      random_pat(int'($urandom_range(8, 45)));
      run_vehicle("random", int'($urandom_range(8, 45)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    int to_cnt, to_idx, val_seen, chg, v;
    random_pat(30);
    for (int i = 0; i <= 10; i++) begin
      sensor_entrada = 1'b1; pulso_eixo = pulso_pat[i]; peso_adc = peso_pat[i];
      aceito = 1'b0; rst = (i == 10);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    last_out = 7'b0;
    checks++;
    if (out_vec !== 7'b0 || valido !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_outputs: out %b valido %b, required 0000000 0", out_vec, valido);
    end
    random_pat(15);
    drive_high(15, 1'b0, to_cnt, to_idx, val_seen, chg);
    checks++;
    if (to_cnt != 0 || val_seen != 0 || chg != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_held: timeout %0d valido %0d changes %0d, required 0 0 0", to_cnt, val_seen, chg);
    end
    idle(4, v);
    checks++;
    if (v != 0) begin
      errors++; $display("[TB] FAIL reset_mid_unarmed: valido cycles %0d, required 0", v);
    end
    random_pat(12);
    run_vehicle("after_reset_mid", 12, 1, 1'b0);
  endtask

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; sensor_entrada = 1'b0; pulso_eixo = 1'b0; peso_adc = 4'd0; aceito = 1'b0;
    last_out = 7'b0;
    clear_pat();
    test_reset();
    test_normal();
    test_glitch();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
